// File: rtl/tx_stream_arbiter_if.sv
// Requester-side and core-side TX streaming signals of tx_stream_arbiter.
// The arbiter connects through the slave modport; the requesters/core model drives the master side.
interface tx_stream_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 75
);
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_np;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         tx_stream_data0;
    logic                      tx_stream_valid0;
    logic                      tx_stream_ready0;
    logic                      tx_stream_mask0;
    logic [NUM_REQ-1:0]        grant;
    logic                      busy;

    modport master (
        output req_data, req_valid, req_np, tx_stream_ready0, tx_stream_mask0,
        input  req_ready, tx_stream_data0, tx_stream_valid0, grant, busy
    );

    modport slave (
        input  req_data, req_valid, req_np, tx_stream_ready0, tx_stream_mask0,
        output req_ready, tx_stream_data0, tx_stream_valid0, grant, busy
    );
endinterface

// File: rtl/tx_stream_arbiter.sv
// Packet-atomic round-robin arbiter sharing the PCIe core TX stream port among NUM_REQ requesters.
// Optional per-requester packet counters are enabled by defining TX_STREAM_ARB_PKT_CNT_EN.
module tx_stream_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 75
) (
    input  logic                 clk,
    input  logic                 rstn,
`ifdef TX_STREAM_ARB_PKT_CNT_EN
    input  logic                 pkt_cnt_clr,
    output logic [NUM_REQ*16-1:0] pkt_cnt,
`endif
    tx_stream_arbiter_if.slave   bus
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SOP_BIT = DATA_W - 2;
    localparam int EOP_BIT = DATA_W - 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t               state_r;
    logic [NUM_REQ-1:0]   grant_r;
    logic [PTR_W-1:0]     ptr_r;
    logic [PTR_W-1:0]     owner_r;
    logic                 busy_r;

    logic [NUM_REQ-1:0]   elig_s;
    logic                 found_s;
    logic [PTR_W-1:0]     sel_s;
    logic [DATA_W-1:0]    owner_beat_s;
    logic                 accept_eop_s;

    // Eligibility: SOP presented, and non-posted packets held off while credits are masked
    always_comb begin
        elig_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_s[i] = bus.req_valid[i] & bus.req_data[i*DATA_W + SOP_BIT]
                        & ~(bus.req_np[i] & bus.tx_stream_mask0);
        end
    end

    // Round-robin scan starting just after the last owner
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        found_s = 1'b0;
        sel_s   = '0;
        idx_v   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_v = PTR_W'((int'(ptr_r) + k) % NUM_REQ);
            if (!found_s && elig_s[idx_v]) begin
                found_s = 1'b1;
                sel_s   = idx_v;
            end else begin
                sel_s   = sel_s;
            end
        end
    end

    assign owner_beat_s = bus.req_data[int'(owner_r)*DATA_W +: DATA_W];

    // Combinational forwarding from the owner; everything is zero while idle
    always_comb begin
        if (state_r == XFER) begin
            bus.tx_stream_data0  = owner_beat_s;
            bus.tx_stream_valid0 = bus.req_valid[owner_r];
            bus.req_ready        = grant_r & {NUM_REQ{bus.tx_stream_ready0}};
        end else begin
            bus.tx_stream_data0  = '0;
            bus.tx_stream_valid0 = 1'b0;
            bus.req_ready        = '0;
        end
    end

    assign accept_eop_s = (state_r == XFER) & bus.tx_stream_valid0 & bus.tx_stream_ready0
                          & owner_beat_s[EOP_BIT];

    // Arbitration FSM: grant held for the whole packet, released on the accepted EOP
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            grant_r <= '0;
            ptr_r   <= PTR_W'(NUM_REQ - 1);
            owner_r <= '0;
            busy_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        grant_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_s;
                        owner_r <= sel_s;
                        busy_r  <= 1'b1;
                        state_r <= XFER;
                    end else begin
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                    end
                end
                XFER: begin
                    if (accept_eop_s) begin
                        ptr_r   <= owner_r;
                        grant_r <= '0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    grant_r <= '0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant = grant_r;
    assign bus.busy  = busy_r;

`ifdef TX_STREAM_ARB_PKT_CNT_EN
    logic [15:0] cnt_r [NUM_REQ];

    // Per-requester EOP counters; clear takes priority over a same-cycle increment
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_r[i] <= 16'h0000;
            end
        end else if (pkt_cnt_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_r[i] <= 16'h0000;
            end
        end else if (accept_eop_s) begin
            cnt_r[owner_r] <= cnt_r[owner_r] + 16'h0001;
        end else begin
            cnt_r[owner_r] <= cnt_r[owner_r];
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        assign pkt_cnt[g*16 +: 16] = cnt_r[g];
    end
`endif

endmodule
